// File: rtl/mem_pkg.sv
// Shared encodings for the byte-wide RAM sequencer: size codes, FSM states,
// latched request control and helpers that derive beat counts and alignment errors.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic       err;
  } req_ctl_t;

  // Number of byte beats on the RAM port; the illegal code never reaches XFER.
  function automatic logic [2:0] beats(input logic [1:0] size);
    case (size)
      SZ_HALF: beats = 3'd2;
      SZ_WORD: beats = 3'd4;
      default: beats = 3'd1;
    endcase
  endfunction

  function automatic logic req_err(input logic [1:0] size, input logic [1:0] alo);
    case (size)
      SZ_BYTE: req_err = 1'b0;
      SZ_HALF: req_err = alo[0];
      SZ_WORD: req_err = |alo;
      default: req_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of the little-endian assembly register to a 32-bit load result.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] asm_in,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic fill;

  always_comb begin
    fill   = 1'b0;
    result = asm_in;
    case (size)
      SZ_BYTE: begin
        fill   = ~uns & asm_in[7];
        result = {{24{fill}}, asm_in[7:0]};
      end
      SZ_HALF: begin
        fill   = ~uns & asm_in[15];
        result = {{16{fill}}, asm_in[15:0]};
      end
      default: result = asm_in;
    endcase
  end

endmodule

// File: rtl/mem_byte_master.sv
// Sequences byte/half/word load-store requests into little-endian byte beats on a
// byte-wide RAM port, assembling and extending load data into a one-cycle response.
module mem_byte_master
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_d,
  output logic              ram_we,
  input  logic [7:0]        ram_q
);

  state_t            state, nstate;
  req_ctl_t          ctl;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;
  logic [31:0]       hold_q;
  logic [31:0]       ext;
  logic [31:0]       resp_now;
  logic [1:0]        beat;
  logic              accept;
  logic              last_beat;

  assign accept    = (state == IDLE) && req_valid;
  assign last_beat = ({1'b0, beat} == beats(ctl.size) - 3'd1);

  mem_load_ext u_ext (
    .asm_in (asm_q),
    .size   (ctl.size),
    .uns    (ctl.uns),
    .result (ext)
  );

  assign resp_now = (ctl.we || ctl.err) ? 32'd0 : ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (req_valid) nstate = req_err(req_size, req_addr[1:0]) ? RESP : XFER;
      XFER: if (last_beat) nstate = RESP;
      RESP: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      hold_q  <= '0;
      beat    <= '0;
    end else begin
      if (accept) begin
        ctl     <= '{we: req_we, size: req_size, uns: req_unsigned,
                     err: req_err(req_size, req_addr[1:0])};
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        asm_q   <= '0;
        beat    <= '0;
      end
      if (state == XFER) begin
        beat <= beat + 2'd1;
        // Async-read RAM: the byte is valid by the edge that ends its beat.
        if (!ctl.we) asm_q[8*beat +: 8] <= ram_q;
      end
      // Keep the last response on resp_rdata once RESP is left.
      if (state == RESP) hold_q <= resp_now;
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && ctl.err;
    resp_rdata = (state == RESP) ? resp_now : hold_q;
    ram_addr   = '0;
    ram_d      = '0;
    ram_we     = 1'b0;
    if (state == XFER) begin
      ram_addr = addr_q + ADDR_W'(beat);
      ram_d    = wdata_q[8*beat +: 8];
      ram_we   = ctl.we;
    end
  end

endmodule
